gpu_fill_engine: RTL and testbench



---
 rtl/gpu_fill_engine.sv | 116 +++++++++++
 tb/tb_gpu_fill_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fill_engine.sv
// Rectangle-fill engine for the GP0 "Fill VRAM" command: walks the rectangle
// row by row and issues one 16-pixel block write per VRAM-arbiter handshake.
module gpu_fill_engine (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_activateFill,
  input  logic [9:0]  i_fillX,
  input  logic [8:0]  i_fillY,
  input  logic [9:0]  i_fillW,
  input  logic [8:0]  i_fillH,
  input  logic [15:0] i_color,
  output logic        o_busy,
  output logic        o_inactiveNextCycle,
  output logic        o_writeReq,
  input  logic        i_writeAck,
  output logic [5:0]  o_writeBlockX,
  output logic [8:0]  o_writeY,
  output logic [15:0] o_writeColor
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t      r_state, w_nextState;
  logic [5:0]  r_startBlk, r_curBlk;
  logic [6:0]  r_blkCount, r_blkLeft;
  logic [8:0]  r_lineCount, r_lineLeft, r_fillY, r_curY;
  logic [15:0] r_color;
  logic [10:0] w_wRounded;
  logic        w_empty, w_lastBlk, w_lastLine;
  logic        w_unusedLowBits;

  // Width rounded up to whole 16-pixel blocks; a 1023-pixel width yields 64.
  assign w_wRounded      = {1'b0, i_fillW} + 11'd15;
  assign w_unusedLowBits = ^{i_fillX[3:0], w_wRounded[3:0]};
  assign w_empty         = (r_blkCount == 7'd0) || (r_lineCount == 9'd0);
  assign w_lastBlk       = (r_blkLeft <= 7'd1);
  assign w_lastLine      = (r_lineLeft <= 9'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_activateFill) w_nextState = LOAD;
      LOAD:    w_nextState = w_empty ? IDLE : WRITE;
      WRITE:   if (i_writeAck && w_lastBlk && w_lastLine) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    o_busy              = (r_state != IDLE);
    o_writeReq          = (r_state == WRITE);
    o_inactiveNextCycle = 1'b0;
    case (r_state)
      LOAD:    o_inactiveNextCycle = w_empty;
      WRITE:   o_inactiveNextCycle = i_writeAck && w_lastBlk && w_lastLine;
      default: o_inactiveNextCycle = 1'b0;
    endcase
  end

  // Block and line coordinates wrap naturally at 64 and 512; nothing is clipped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_startBlk  <= '0;
      r_blkCount  <= '0;
      r_lineCount <= '0;
      r_fillY     <= '0;
      r_color     <= '0;
      r_curBlk    <= '0;
      r_curY      <= '0;
      r_blkLeft   <= '0;
      r_lineLeft  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_activateFill) begin
            r_startBlk  <= i_fillX[9:4];
            r_blkCount  <= w_wRounded[10:4];
            r_lineCount <= i_fillH;
            r_fillY     <= i_fillY;
            r_color     <= i_color;
          end
        end
        LOAD: begin
          r_curBlk   <= r_startBlk;
          r_curY     <= r_fillY;
          r_blkLeft  <= r_blkCount;
          r_lineLeft <= r_lineCount;
        end
        WRITE: begin
          if (i_writeAck) begin
            if (!w_lastBlk) begin
              r_curBlk  <= r_curBlk + 6'd1;
              r_blkLeft <= r_blkLeft - 7'd1;
            end else if (!w_lastLine) begin
              r_curBlk   <= r_startBlk;
              r_blkLeft  <= r_blkCount;
              r_curY     <= r_curY + 9'd1;
              r_lineLeft <= r_lineLeft - 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_writeBlockX = r_curBlk;
  assign o_writeY      = r_curY;
  assign o_writeColor  = r_color;

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine: directed fills push expected block
// writes into a queue, a negedge monitor pops and compares on each handshake.
module tb_gpu_fill_engine;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_activateFill = 1'b0;
  logic [9:0]  i_fillX = '0;
  logic [8:0]  i_fillY = '0;
  logic [9:0]  i_fillW = '0;
  logic [8:0]  i_fillH = '0;
  logic [15:0] i_color = '0;
  logic        i_writeAck = 1'b0;
  logic        o_busy, o_inactiveNextCycle, o_writeReq;
  logic [5:0]  o_writeBlockX;
  logic [8:0]  o_writeY;
  logic [15:0] o_writeColor;

  gpu_fill_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_activateFill(i_activateFill),
    .i_fillX(i_fillX), .i_fillY(i_fillY), .i_fillW(i_fillW), .i_fillH(i_fillH),
    .i_color(i_color), .o_busy(o_busy), .o_inactiveNextCycle(o_inactiveNextCycle),
    .o_writeReq(o_writeReq), .i_writeAck(i_writeAck), .o_writeBlockX(o_writeBlockX),
    .o_writeY(o_writeY), .o_writeColor(o_writeColor)
  );

  always #5 i_clk = ~i_clk;

  int testsRun = 0;
  int testsFailed = 0;
  int busyCycles = 0;
  int pulses = 0;
  int writesDone = 0;
  int stallCnt = 0;
  logic stallMode = 1'b0;
  logic prevStall = 1'b0;
  logic prevInactive = 1'b0;
  logic [30:0] prevPayload = '0;
  logic [30:0] payload;
  logic [30:0] expQ[$];

  function automatic logic [30:0] pack(input int blk, input int y, input logic [15:0] c);
    logic [5:0] b6;
    logic [8:0] y9;
    b6 = blk[5:0];
    y9 = y[8:0];
    return {b6, y9, c};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Arbiter model: ack tied high, or held low three cycles per request when stalling.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (!stallMode) begin
        i_writeAck = 1'b1;
        stallCnt = 0;
      end else if (o_writeReq) begin
        if (stallCnt == 3) begin
          i_writeAck = 1'b1;
          stallCnt = 0;
        end else begin
          i_writeAck = 1'b0;
          stallCnt++;
        end
      end else begin
        i_writeAck = 1'b0;
        stallCnt = 0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      prevStall = 1'b0;
      prevInactive = 1'b0;
    end else begin
      payload = {o_writeBlockX, o_writeY, o_writeColor};
      if (prevStall && o_writeReq) checkOutput("stallStable", {1'b0, payload}, {1'b0, prevPayload});
      if (prevInactive) checkOutput("busyAfterDone", {31'd0, o_busy}, 32'd0);
      if (o_busy) busyCycles++;
      if (o_inactiveNextCycle) pulses++;
      if (o_writeReq && !i_writeAck) checkOutput("noDoneWhileStalled", {31'd0, o_inactiveNextCycle}, 32'd0);
      if (o_writeReq && i_writeAck) begin
        writesDone++;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedWrite: got 0x%0h, expected no write", payload);
        end else begin
          checkOutput("writePayload", {1'b0, payload}, {1'b0, expQ.pop_front()});
        end
        if (o_inactiveNextCycle) checkOutput("doneOnLastAck", expQ.size(), 32'd0);
      end
      prevStall = o_writeReq && !i_writeAck;
      prevPayload = payload;
      prevInactive = o_inactiveNextCycle;
    end
  end

  task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                               input logic [8:0] h, input logic [15:0] c);
    busyCycles = 0;
    pulses = 0;
    writesDone = 0;
    @(posedge i_clk);
    #1;
    i_fillX = x; i_fillY = y; i_fillW = w; i_fillH = h; i_color = c;
    i_activateFill = 1'b1;
    @(posedge i_clk);
    #1;
    i_activateFill = 1'b0;
    i_fillX = ~x; i_fillY = ~y; i_fillW = ~w; i_fillH = ~h; i_color = ~c;
  endtask

  task automatic waitIdle(input string name, input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge i_clk);
      #1;
      if (!o_busy) done = 1;
    end
    if (!done) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: busy still %0b, required 0", name, o_busy);
    end
  endtask

  task automatic checkFill(input string name, input int expBusy, input int expWrites);
    checkOutput({name, "_busyCycles"}, busyCycles, expBusy);
    checkOutput({name, "_pulses"}, pulses, 32'd1);
    checkOutput({name, "_writes"}, writesDone, expWrites);
    checkOutput({name, "_queueEmpty"}, expQ.size(), 32'd0);
    expQ.delete();
  endtask

  initial begin
    bit reached;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rstBusy", {31'd0, o_busy}, 32'd0);
    checkOutput("rstDone", {31'd0, o_inactiveNextCycle}, 32'd0);
    checkOutput("rstReq", {31'd0, o_writeReq}, 32'd0);
    checkOutput("rstBlockX", {26'd0, o_writeBlockX}, 32'd0);
    checkOutput("rstY", {23'd0, o_writeY}, 32'd0);
    checkOutput("rstColor", {16'd0, o_writeColor}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Two blocks by two lines, Y wrapping 511 -> 0
    expQ.push_back(pack(1, 511, 16'h7C1F));
    expQ.push_back(pack(2, 511, 16'h7C1F));
    expQ.push_back(pack(1, 0, 16'h7C1F));
    expQ.push_back(pack(2, 0, 16'h7C1F));
    applyStimulus(10'h013, 9'h1FF, 10'h011, 9'd2, 16'h7C1F);
    waitIdle("wrapY", 50);
    checkFill("wrapY", 5, 4);

    // Empty rectangles finish in the LOAD cycle
    applyStimulus(10'd0, 9'd0, 10'd0, 9'd5, 16'h1111);
    @(negedge i_clk);
    #1;
    checkOutput("emptyW_doneInLoad", {31'd0, o_inactiveNextCycle}, 32'd1);
    checkOutput("emptyW_noReq", {31'd0, o_writeReq}, 32'd0);
    waitIdle("emptyW", 10);
    checkFill("emptyW", 1, 0);

    applyStimulus(10'd0, 9'd0, 10'd8, 9'd0, 16'h2222);
    @(negedge i_clk);
    #1;
    checkOutput("emptyH_doneInLoad", {31'd0, o_inactiveNextCycle}, 32'd1);
    checkOutput("emptyH_noReq", {31'd0, o_writeReq}, 32'd0);
    waitIdle("emptyH", 10);
    checkFill("emptyH", 1, 0);

    // Block column wrapping 63 -> 0
    expQ.push_back(pack(63, 10, 16'h03E0));
    expQ.push_back(pack(0, 10, 16'h03E0));
    expQ.push_back(pack(1, 10, 16'h03E0));
    applyStimulus(10'h3F0, 9'd10, 10'h030, 9'd1, 16'h03E0);
    waitIdle("wrapX", 50);
    checkFill("wrapX", 4, 3);

    // Arbiter stalls three cycles per request
    stallMode = 1'b1;
    expQ.push_back(pack(0, 0, 16'h8001));
    expQ.push_back(pack(1, 0, 16'h8001));
    applyStimulus(10'd0, 9'd0, 10'h020, 9'd1, 16'h8001);
    waitIdle("stall", 50);
    checkFill("stall", 9, 2);
    stallMode = 1'b0;

    // Reset two acks into a 4x4-block fill, then rerun the same rectangle
    for (int y = 0; y < 4; y++)
      for (int b = 0; b < 4; b++) expQ.push_back(pack(b, y, 16'h5555));
    applyStimulus(10'd0, 9'd0, 10'd64, 9'd4, 16'h5555);
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(negedge i_clk);
      #1;
      if (writesDone == 2) reached = 1;
    end
    if (!reached) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL midReset_twoAcks: got %0d writes, required 2", writesDone);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    checkOutput("midReset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("midReset_done", {31'd0, o_inactiveNextCycle}, 32'd0);
    checkOutput("midReset_req", {31'd0, o_writeReq}, 32'd0);
    checkOutput("midReset_payload", {1'b0, o_writeBlockX, o_writeY, o_writeColor}, 32'd0);
    checkOutput("midReset_noPulse", pulses, 32'd0);
    expQ.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    for (int y = 0; y < 4; y++)
      for (int b = 0; b < 4; b++) expQ.push_back(pack(b, y, 16'h2AAA));
    applyStimulus(10'd0, 9'd0, 10'd64, 9'd4, 16'h2AAA);
    waitIdle("afterReset", 60);
    checkFill("afterReset", 17, 16);

    // A second activate with a new colour during a fill is ignored
    stallMode = 1'b1;
    expQ.push_back(pack(2, 100, 16'h1234));
    expQ.push_back(pack(3, 100, 16'h1234));
    expQ.push_back(pack(2, 101, 16'h1234));
    expQ.push_back(pack(3, 101, 16'h1234));
    applyStimulus(10'h020, 9'd100, 10'd32, 9'd2, 16'h1234);
    repeat (3) @(posedge i_clk);
    #1;
    i_fillX = 10'd0; i_fillY = 9'd0; i_fillW = 10'd1023; i_fillH = 9'd511; i_color = 16'hFFFF;
    i_activateFill = 1'b1;
    @(posedge i_clk);
    #1;
    i_activateFill = 1'b0;
    waitIdle("ignoreAct", 100);
    checkFill("ignoreAct", 17, 4);
    stallMode = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("ignoreAct_staysIdle", {31'd0, o_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
